// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_rr_arbiter.
// The arbiter uses the slave modport; the clients/ALU side uses master.
interface alu_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_opcode;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_opcode;
    logic [3:0]        alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [3:0]        rsp_result;
    logic              busy;
    logic [CNT_W-1:0]  ops_done;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id,
               rsp_result, busy, ops_done
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id,
               rsp_result, busy, ops_done
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between NREQ clients.
// One op in flight at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold).
module alu_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_rr_arbiter_if.slave       bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [3:0]       r_rsp_result;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_found;
    logic [ID_W-1:0]  w_grant;
    int               w_sel;

    // Scan starts one past the last grant so the previous winner ranks last.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_grant = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
        w_sel = int'(w_grant);
    end

    assign bus.req_ready  = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_grant) : '0;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.ops_done   = r_ops_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= ID_W'(NREQ - 1);
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_alu_a  <= bus.req_a[w_sel*4 +: 4];
                        r_alu_b  <= bus.req_b[w_sel*4 +: 4];
                        r_alu_op <= bus.req_opcode[w_sel*3 +: 3];
                        r_rsp_id <= w_grant;
                        r_ptr    <= w_grant;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: scoreboard of expected {id,result} popped
// by a response monitor, plus direct checks on handshake, hold and reset state.
module tb_alu_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      res;
    } exp_t;
    exp_t sb[$];

    alu_rr_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus();

    alu_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: add, sub, mul, and, or, xor, shl1, pass-a
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[3:0];
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a << 1;
            default: return a;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d result %0h expected none",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        bus.req_a[4*i +: 4]      = a;
        bus.req_b[4*i +: 4]      = b;
        bus.req_opcode[3*i +: 3] = op;
    endtask

    // Wait for a grant, check it is the expected one-hot, then pass the accept edge.
    task automatic accept(input int g, input logic [3:0] res, input bit push);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|bus.req_ready) seen = 1'b1;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(1 << g));
        e.id  = ID_W'(g);
        e.res = res;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("rsp_valid_seen", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_opcode = '0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", {bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_result},
            32'd0);
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_opcode}, 32'd0);
        chk("rst_ops_done", 32'(bus.ops_done), 32'd0);
        @(posedge clk);
        #1;

        // single request, 9+9 truncates to 2, two-edge latency
        set_req(0, 4'd9, 4'd9, 3'd0);
        bus.req_valid = 4'b0001;
        accept(0, 4'd2, 1'b1);
        bus.req_valid = '0;
        @(negedge clk);
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("exec_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_ops_done", 32'(bus.ops_done), 32'd1);
        chk("single_idle", 32'(bus.busy), 32'd0);

        // round robin from a fresh pointer: 0,1,2,3,0
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'd3, 3'd2);
        bus.req_valid = 4'b1111;
        accept(0, 4'd3, 1'b1);
        accept(1, 4'd6, 1'b1);
        accept(2, 4'd9, 1'b1);
        accept(3, 4'd12, 1'b1);
        accept(0, 4'd3, 1'b1);
        bus.req_valid = '0;
        drain();

        // backpressure: 3-5 = 14 held for 5 cycles while requester 0 waits
        bus.rsp_ready = 1'b0;
        set_req(2, 4'd3, 4'd5, 3'd1);
        bus.req_valid = 4'b0100;
        accept(2, 4'd14, 1'b1);
        set_req(0, 4'd1, 4'd1, 3'd0);
        bus.req_valid = 4'b0001;
        wait_rsp();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready},
                {21'd0, 1'b1, 2'd2, 4'd14, 4'b0000});
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        accept(0, 4'd2, 1'b1);
        bus.req_valid = '0;
        drain();

        // operands captured at accept: 7*3 = 21 -> 5
        set_req(1, 4'd7, 4'd3, 3'd2);
        bus.req_valid = 4'b0010;
        accept(1, 4'd5, 1'b1);
        bus.req_valid = '0;
        set_req(1, 4'd0, 4'd0, 3'd2);
        drain();

        // withdraw: requester 1 drops before IDLE, 3 wins, then scan restarts at 0
        set_req(0, 4'd2, 4'd2, 3'd0);
        bus.req_valid = 4'b0001;
        accept(0, 4'd4, 1'b1);
        set_req(1, 4'd1, 4'd1, 3'd0);
        set_req(3, 4'd6, 4'd12, 3'd3);
        bus.req_valid = 4'b1010;
        @(posedge clk);
        #1 bus.req_valid = 4'b1000;
        accept(3, 4'd4, 1'b1);
        set_req(0, 4'd5, 4'd6, 3'd4);
        set_req(2, 4'd15, 4'd1, 3'd0);
        bus.req_valid = 4'b0101;
        accept(0, 4'd7, 1'b1);
        bus.req_valid = 4'b0100;
        accept(2, 4'd0, 1'b1);
        bus.req_valid = '0;
        drain();

        // reset during RESP aborts the op
        bus.rsp_ready = 1'b0;
        set_req(0, 4'd1, 4'd2, 3'd0);
        bus.req_valid = 4'b0001;
        accept(0, 4'd3, 1'b0);
        bus.req_valid = '0;
        wait_rsp();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midop_busy", 32'(bus.busy), 32'd0);
        chk("midop_ops_done", 32'(bus.ops_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(1, 4'd3, 4'd3, 3'd0);
        bus.req_valid = 4'b0011;
        accept(0, 4'd3, 1'b1);
        bus.req_valid = 4'b0010;
        accept(1, 4'd6, 1'b1);
        bus.req_valid = '0;
        drain();
        @(negedge clk);
        chk("final_ops_done", 32'(bus.ops_done), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
